// File: rtl/stream_to_mem_mux_pkg.sv
// +----------------------------------------------------------------------------+
// | stream_to_mem_mux_pkg                                                      |
// | Shared width helpers and arbiter state type for the stream-to-memory mux.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package stream_to_mem_mux_pkg;

    // Port index width; a single port still needs one bit to carry an index.
    function automatic int unsigned idx_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    typedef enum logic [0:0] {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/stream_to_mem_mux_if.sv
// +----------------------------------------------------------------------------+
// | stream_to_mem_mux_if                                                       |
// | Request/response streams plus the single memory port of the mux.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface stream_to_mem_mux_if #(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned ReqWidth  = 64,
    parameter int unsigned RespWidth = 32
);
    logic [NumPorts*ReqWidth-1:0]  req_i;
    logic [NumPorts-1:0]           req_valid_i;
    logic [NumPorts-1:0]           req_ready_o;
    logic [NumPorts*RespWidth-1:0] resp_o;
    logic [NumPorts-1:0]           resp_valid_o;
    logic [NumPorts-1:0]           resp_ready_i;
    logic [ReqWidth-1:0]           mem_req_o;
    logic                          mem_req_valid_o;
    logic                          mem_req_ready_i;
    logic [RespWidth-1:0]          mem_resp_i;
    logic                          mem_resp_valid_i;

    // Mux side of the bundle.
    modport slave (
        input  req_i, req_valid_i, resp_ready_i, mem_req_ready_i, mem_resp_i, mem_resp_valid_i,
        output req_ready_o, resp_o, resp_valid_o, mem_req_o, mem_req_valid_o
    );

    // Environment side: requesters and memory.
    modport master (
        output req_i, req_valid_i, resp_ready_i, mem_req_ready_i, mem_resp_i, mem_resp_valid_i,
        input  req_ready_o, resp_o, resp_valid_o, mem_req_o, mem_req_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/stream_fifo.sv
// +----------------------------------------------------------------------------+
// | stream_fifo                                                                |
// | Generic valid/ready FIFO, optionally fall-through when empty.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 2
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic [DATA_WIDTH-1:0] data_i,
    input  wire logic                  valid_i,
    output logic                       ready_o,
    output logic      [DATA_WIDTH-1:0] data_o,
    output logic                       valid_o,
    input  wire logic                  ready_i
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign ready_o = !w_full;

    generate
        if (FALL_THROUGH) begin : g_fall_through
            // Empty FIFO forwards the input; a same-cycle consumer skips storage.
            assign valid_o  = !w_empty || valid_i;
            assign data_o   = w_empty ? data_i : r_mem[r_rd_ptr];
            assign w_bypass = w_empty && ready_i;
        end else begin : g_registered
            assign valid_o  = !w_empty;
            assign data_o   = r_mem[r_rd_ptr];
            assign w_bypass = 1'b0;
        end
    endgenerate

    assign w_push = valid_i && !w_full && !w_bypass;
    assign w_pop  = ready_i && !w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_to_mem_rr_arb.sv
// +----------------------------------------------------------------------------+
// | stream_to_mem_rr_arb                                                       |
// | Round-robin arbiter that holds its grant until the handshake completes.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_to_mem_rr_arb
    import stream_to_mem_mux_pkg::*;
#(
    parameter int unsigned NumPorts = 2
) (
    input  wire logic                             clk_i,
    input  wire logic                             rst_ni,
    input  wire logic [NumPorts-1:0]              eligible_i,
    input  wire logic                             ready_i,
    output logic      [idx_width(NumPorts)-1:0]   gnt_idx_o,
    output logic                                  gnt_valid_o
);
    localparam int unsigned IDX_W = idx_width(NumPorts);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_lock_idx_next;
    logic [IDX_W-1:0] w_search_idx;
    logic             w_search_hit;
    logic [NumPorts-1:0] w_rot;

    // Bit i of w_rot is the eligibility of port (ptr + i) mod NumPorts.
    assign w_rot = NumPorts'({eligible_i, eligible_i} >> r_ptr);

    always_comb begin
        w_search_idx = '0;
        w_search_hit = 1'b0;
        // Walk from the farthest offset so the nearest eligible port wins.
        for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_search_hit = 1'b1;
                w_search_idx = IDX_W'((int'(r_ptr) + i) % int'(NumPorts));
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_lock_idx_next = r_lock_idx;
        gnt_valid_o     = w_search_hit;
        gnt_idx_o       = w_search_idx;
        if (r_state == ARB_LOCKED) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = r_lock_idx;
        end
        if (gnt_valid_o && ready_i) begin
            w_state_next = ARB_FREE;
            w_ptr_next   = IDX_W'((int'(gnt_idx_o) + 1) % int'(NumPorts));
        end else if (gnt_valid_o) begin
            w_state_next    = ARB_LOCKED;
            w_lock_idx_next = gnt_idx_o;
        end else begin
            w_state_next = ARB_FREE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_FREE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_lock_idx <= w_lock_idx_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_to_mem_mux.sv
// +----------------------------------------------------------------------------+
// | stream_to_mem_mux                                                          |
// | Muxes NumPorts request streams onto one in-order memory port and routes    |
// | responses back. STREAM_TO_MEM_MUX_ERR_EN enables the sticky err_o flag.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_to_mem_mux
    import stream_to_mem_mux_pkg::*;
#(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RespWidth      = 32,
    parameter int unsigned BufDepth       = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    stream_to_mem_mux_if.slave bus,
    output logic               err_o
);
    localparam int unsigned IDX_W = idx_width(NumPorts);
    localparam int unsigned CRD_W = cnt_width(BufDepth);
    localparam int unsigned OUT_W = cnt_width(MaxOutstanding);

    logic [NumPorts-1:0] w_eligible;
    logic [NumPorts-1:0] w_resp_fifo_ready;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [IDX_W-1:0]    w_idx_head;
    logic                w_gnt_valid;
    logic                w_mem_hs;
    logic                w_idx_valid;
    logic                w_idx_ready;
    logic                w_idx_pop;
    logic                w_outst_ok;
    logic [OUT_W-1:0]    r_outstanding;

    assign w_outst_ok = (r_outstanding < OUT_W'(MaxOutstanding));
    assign w_mem_hs   = w_gnt_valid && bus.mem_req_ready_i;
    assign w_idx_pop  = bus.mem_resp_valid_i && w_idx_valid;

    stream_to_mem_rr_arb #(
        .NumPorts (NumPorts)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .eligible_i  (w_eligible),
        .ready_i     (bus.mem_req_ready_i),
        .gnt_idx_o   (w_gnt_idx),
        .gnt_valid_o (w_gnt_valid)
    );

    assign bus.mem_req_valid_o = w_gnt_valid;
    assign bus.mem_req_o       = bus.req_i[w_gnt_idx*ReqWidth +: ReqWidth];

    // Remembers which port owns each in-flight memory transaction, oldest first.
    stream_fifo #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IDX_W),
        .DEPTH        (MaxOutstanding)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (w_gnt_idx),
        .valid_i (w_mem_hs),
        .ready_o (w_idx_ready),
        .data_o  (w_idx_head),
        .valid_o (w_idx_valid),
        .ready_i (bus.mem_resp_valid_i)
    );

    generate
        for (genvar p = 0; p < NumPorts; p++) begin : g_port
            logic [CRD_W-1:0] r_credit;
            logic             w_crd_inc;
            logic             w_crd_dec;
            logic             w_resp_push;

            // Credit is the registered value, so a same-cycle release does not help.
            assign w_eligible[p]       = bus.req_valid_i[p] && (r_credit < CRD_W'(BufDepth)) && w_outst_ok;
            assign bus.req_ready_o[p]  = w_gnt_valid && bus.mem_req_ready_i && (w_gnt_idx == IDX_W'(p));
            assign w_crd_inc           = w_mem_hs && (w_gnt_idx == IDX_W'(p));
            assign w_crd_dec           = bus.resp_valid_o[p] && bus.resp_ready_i[p];
            assign w_resp_push         = w_idx_pop && (w_idx_head == IDX_W'(p));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_credit <= '0;
                end else if (w_crd_inc && !w_crd_dec) begin
                    r_credit <= r_credit + CRD_W'(1);
                end else if (!w_crd_inc && w_crd_dec) begin
                    r_credit <= r_credit - CRD_W'(1);
                end
            end

            stream_fifo #(
                .FALL_THROUGH (1'b1),
                .DATA_WIDTH   (RespWidth),
                .DEPTH        (BufDepth)
            ) u_resp_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .data_i  (bus.mem_resp_i),
                .valid_i (w_resp_push),
                .ready_o (w_resp_fifo_ready[p]),
                .data_o  (bus.resp_o[p*RespWidth +: RespWidth]),
                .valid_o (bus.resp_valid_o[p]),
                .ready_i (bus.resp_ready_i[p])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else if (w_mem_hs && !w_idx_pop) begin
            r_outstanding <= r_outstanding + OUT_W'(1);
        end else if (!w_mem_hs && w_idx_pop) begin
            r_outstanding <= r_outstanding - OUT_W'(1);
        end
    end

`ifdef STREAM_TO_MEM_MUX_ERR_EN
    logic r_err;

    // A response with nothing in flight has no owner; flag it until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (bus.mem_resp_valid_i && !w_idx_valid) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    // Credits and the outstanding limit already guarantee room in every FIFO.
    logic w_unused_ok;
    assign w_unused_ok = ^{w_idx_ready, w_resp_fifo_ready};

endmodule

`default_nettype wire

// File: tb/tb_stream_to_mem_mux.sv
// +----------------------------------------------------------------------------+
// | tb_stream_to_mem_mux                                                       |
// | Directed and randomized checks of stream_to_mem_mux against a queue model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stream_to_mem_mux;
    localparam int NP = 2;
    localparam int RW = 64;
    localparam int SW = 32;
    localparam int BD = 2;
    localparam int MO = 4;
`ifdef STREAM_TO_MEM_MUX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic err;

    always #5 clk = ~clk;

    stream_to_mem_mux_if #(.NumPorts(NP), .ReqWidth(RW), .RespWidth(SW)) bus ();

    stream_to_mem_mux #(
        .NumPorts(NP), .ReqWidth(RW), .RespWidth(SW), .BufDepth(BD), .MaxOutstanding(MO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus),
        .err_o  (err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Stimulus knobs (percent probabilities).
    int req_prob [NP];
    int ready_prob [NP];
    int mem_ready_prob;
    int mem_resp_prob;
    bit gen_en;
    bit spur;

    // Reference model: pending requester payloads, in-flight owners, per-port buffers.
    bit             pend_v [NP];
    logic [RW-1:0]  pend_d [NP];
    int             mem_q [$];
    logic [SW-1:0]  buf_q [NP][$];
    int             rr_ptr;
    bit             locked;
    int             lock_port;
    bit             exp_err;
    int             dut_hs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy();
        bit b = (mem_q.size() > 0);
        for (int p = 0; p < NP; p++) b |= pend_v[p] || (buf_q[p].size() > 0);
        return b;
    endfunction

    task automatic idle_inputs();
        bus.req_i = '0;
        bus.req_valid_i = '0;
        bus.resp_ready_i = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_resp_i = '0;
        bus.mem_resp_valid_i = 1'b0;
    endtask

    // One clock: drive at posedge+1, predict, compare at negedge, advance model.
    task automatic cycle();
        int          cred [NP];
        bit          elig [NP];
        bit          exp_v [NP];
        bit          gv;
        int          g;
        bit          inc_v;
        int          inc_port;
        logic [SW-1:0] rdata;
        logic [NP-1:0] exp_rr;
        logic [SW-1:0] exp_d;

        for (int p = 0; p < NP; p++) begin
            if (!pend_v[p] && gen_en && (int'($urandom_range(99)) < req_prob[p])) begin
                pend_v[p] = 1'b1;
                pend_d[p] = {$urandom, $urandom};
            end
            bus.req_valid_i[p] = pend_v[p];
            bus.req_i[p*RW +: RW] = pend_d[p];
            bus.resp_ready_i[p] = (int'($urandom_range(99)) < ready_prob[p]);
        end
        bus.mem_req_ready_i = (int'($urandom_range(99)) < mem_ready_prob);
        bus.mem_resp_valid_i = spur || ((mem_q.size() > 0) && (int'($urandom_range(99)) < mem_resp_prob));
        rdata = $urandom;
        bus.mem_resp_i = rdata;

        for (int p = 0; p < NP; p++) cred[p] = buf_q[p].size();
        foreach (mem_q[k]) cred[mem_q[k]]++;
        for (int p = 0; p < NP; p++) elig[p] = pend_v[p] && (cred[p] < BD) && (mem_q.size() < MO);
        gv = 1'b0;
        g = 0;
        if (locked) begin
            gv = 1'b1;
            g = lock_port;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (!gv && elig[(rr_ptr + k) % NP]) begin
                    gv = 1'b1;
                    g = (rr_ptr + k) % NP;
                end
            end
        end
        inc_v = bus.mem_resp_valid_i && (mem_q.size() > 0);
        inc_port = inc_v ? mem_q[0] : -1;

        @(negedge clk);
        chk("mem_req_valid", 64'(bus.mem_req_valid_o), 64'(gv));
        if (gv) chk("mem_req_data", bus.mem_req_o, pend_d[g]);
        exp_rr = '0;
        if (gv && bus.mem_req_ready_i) exp_rr[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rr));
        for (int p = 0; p < NP; p++) begin
            exp_v[p] = (buf_q[p].size() > 0) || (inc_v && inc_port == p);
            chk($sformatf("resp_valid[%0d]", p), 64'(bus.resp_valid_o[p]), 64'(exp_v[p]));
            if (exp_v[p]) begin
                exp_d = (buf_q[p].size() > 0) ? buf_q[p][0] : rdata;
                chk($sformatf("resp_data[%0d]", p), 64'(bus.resp_o[p*SW +: SW]), 64'(exp_d));
            end
        end
        chk("err", 64'(err), 64'(exp_err));
        if (bus.mem_req_valid_o && bus.mem_req_ready_i) dut_hs++;

        if (inc_v) begin
            void'(mem_q.pop_front());
            buf_q[inc_port].push_back(rdata);
        end
        if (bus.mem_resp_valid_i && !inc_v && ERR_EN) exp_err = 1'b1;
        for (int p = 0; p < NP; p++) begin
            if (exp_v[p] && bus.resp_ready_i[p]) void'(buf_q[p].pop_front());
        end
        if (gv && bus.mem_req_ready_i) begin
            mem_q.push_back(g);
            pend_v[g] = 1'b0;
            rr_ptr = (g + 1) % NP;
            locked = 1'b0;
        end else if (gv) begin
            locked = 1'b1;
            lock_port = g;
        end else begin
            locked = 1'b0;
        end

        @(posedge clk);
        #1;
    endtask

    // Memory side is reset together with the mux, so the model drops everything.
    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        for (int p = 0; p < NP; p++) begin
            pend_v[p] = 1'b0;
            buf_q[p].delete();
        end
        mem_q.delete();
        rr_ptr = 0;
        locked = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        gen_en = 1'b0;
        mem_ready_prob = 100;
        mem_resp_prob = 100;
        for (int p = 0; p < NP; p++) ready_prob[p] = 100;
        while (busy() && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_in_budget", 64'(n < 200), 64'd1);
    endtask

    task automatic set_all(input int rq, input int rd, input int mr, input int rs);
        for (int p = 0; p < NP; p++) begin
            req_prob[p] = rq;
            ready_prob[p] = rd;
        end
        mem_ready_prob = mr;
        mem_resp_prob = rs;
    endtask

    initial begin
        spur = 1'b0;
        gen_en = 1'b0;
        dut_hs = 0;
        set_all(0, 100, 100, 100);
        @(posedge clk);
        #1;
        do_reset();

        // Both ports streaming, single-cycle memory: alternating grants.
        gen_en = 1'b1;
        set_all(100, 100, 100, 100);
        repeat (20) cycle();
        drain();

        // Grant lock while memory stalls; port 1 joins during the stall.
        gen_en = 1'b1;
        set_all(0, 100, 0, 100);
        req_prob[0] = 100;
        cycle();
        req_prob[1] = 100;
        cycle();
        cycle();
        req_prob[0] = 0;
        req_prob[1] = 0;
        mem_ready_prob = 100;
        repeat (4) cycle();
        drain();

        // Port 0 stops consuming: its credits run out, port 1 keeps going.
        gen_en = 1'b1;
        set_all(100, 100, 100, 100);
        ready_prob[0] = 0;
        repeat (16) cycle();
        chk("port0_blocked", 64'(bus.req_ready_o[0]), 64'd0);
        ready_prob[0] = 100;
        repeat (6) cycle();
        drain();

        // Memory withholds responses: only MaxOutstanding handshakes get through.
        gen_en = 1'b1;
        set_all(100, 100, 100, 0);
        dut_hs = 0;
        repeat (10) cycle();
        chk("outstanding_limit_hs", 64'(dut_hs), 64'(MO));
        chk("outstanding_limit_valid", 64'(bus.mem_req_valid_o), 64'd0);
        dut_hs = 0;
        mem_resp_prob = 100;
        cycle();
        mem_resp_prob = 0;
        repeat (4) cycle();
        chk("one_resp_one_req", 64'(dut_hs), 64'd1);
        drain();

        // Randomized traffic, then reset in the middle of it.
        gen_en = 1'b1;
        for (int blk = 0; blk < 6; blk++) begin
            for (int p = 0; p < NP; p++) begin
                req_prob[p] = int'($urandom_range(100, 20));
                ready_prob[p] = int'($urandom_range(100, 30));
            end
            mem_ready_prob = int'($urandom_range(90, 30));
            mem_resp_prob = int'($urandom_range(90, 30));
            repeat (50) cycle();
        end
        do_reset();
        gen_en = 1'b1;
        set_all(70, 60, 70, 60);
        repeat (80) cycle();
        drain();

        // Spurious response with nothing in flight.
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        repeat (3) cycle();
        do_reset();
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/stream_to_mem_mux.md
Name: stream_to_mem_mux

Overview:
Multi-port successor to the single-stream request/response memory adapter. Arbitrates NumPorts request streams round-robin onto one memory port. Supports up to MaxOutstanding in-order memory transactions. Routes each memory response back to its originating port through a per-port fall-through response buffer. Sits between several bus-side masters (e.g. per-channel AXI-to-mem front ends) and one SRAM/bank-controller port that responds in order and has no response backpressure.

Parameters:
NumPorts, 2, number of request/response stream pairs (>=1)
ReqWidth, 64, bits per request payload (opaque, passed through)
RespWidth, 32, bits per response payload (opaque)
BufDepth, 2, per-port response buffer depth = per-port credit count (>=1)
MaxOutstanding, 4, total in-flight memory transactions; also the depth of the index FIFO (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  NumPorts*ReqWidth  request payload, port p at [p*ReqWidth +: ReqWidth]
req_valid_i  in  NumPorts  per-port request valid
req_ready_o  out  NumPorts  per-port request ready
resp_o  out  NumPorts*RespWidth  per-port response payload
resp_valid_o  out  NumPorts  per-port response valid
resp_ready_i  in  NumPorts  per-port response ready
mem_req_o  out  ReqWidth  request payload of the granted port
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory request ready
mem_resp_i  in  RespWidth  memory response payload
mem_resp_valid_i  in  1  memory response valid (no ready; must be accepted)
err_o  out  1  sticky spurious-response flag (see Optional Feature)

Behaviour:
- Reset: all of the following are cleared.
  - Round-robin pointer = 0; lock = 0; credit counters = 0; outstanding counter = 0.
  - All FIFOs empty; err_o = 0.
  - All valid/ready outputs are 0 while inputs are idle.
- Eligibility of port p: req_valid_i[p] && credit[p] < BufDepth && outstanding < MaxOutstanding.
- Arbitration (combinational, 0-cycle request latency):
  - Grant the first eligible port at or after the RR pointer.
  - mem_req_valid_o = any eligible; mem_req_o = req_i of the granted port.
  - req_ready_o[g] = mem_req_ready_i for the granted port only; 0 for all others.
- Grant lock:
  - If mem_req_valid_o=1 and mem_req_ready_i=0, register the grant.
  - The next cycle keeps the same port; valid and data must stay stable, and requesters must hold valid.
  - The lock clears on handshake.
- On memory handshake:
  - RR pointer <= (g+1) mod NumPorts.
  - Push g into the index FIFO (width $clog2(NumPorts), min 1).
  - credit[g]++; outstanding++.
- Memory response:
  - Arrives >=1 cycle after its request handshake, in request order.
  - On mem_resp_valid_i, pop the index FIFO; push mem_resp_i into that port's response FIFO; outstanding--.
  - The FIFO cannot overflow, because the credit was reserved at request time.
- Response FIFO is fall-through: an empty FIFO presents the response on resp_o in the same cycle as mem_resp_valid_i.
- On resp_valid_o[p] && resp_ready_i[p]: credit[p]--.
- Simultaneous events:
  - Credit/outstanding increment and decrement in the same cycle: net unchanged.
  - Port at credit==BufDepth that is consuming a response this cycle: NOT eligible. Credit is checked against the registered value, which keeps the timing path short.
- Boundaries:
  - outstanding==MaxOutstanding: mem_req_valid_o=0 unless locked. A locked request stays valid; it was granted before the limit was reached.
  - NumPorts=1: no arbitration; pointer constant 0.
  - Counter widths are $clog2(limit+1).
- Reset mid-operation: all in-flight state is discarded. The memory side must also be reset.

Optional Feature:
STREAM_TO_MEM_MUX_ERR_EN.
- Defined: mem_resp_valid_i while the index FIFO is empty sets err_o, sticky until reset. The response is dropped and no counter changes.
- Undefined: err_o tied 0. Spurious responses are dropped silently; no error logic is synthesized.

Decomposition:
- Package stream_to_mem_mux_pkg: idx_width(NumPorts) function and credit/outstanding width helper constants.
- Sub-module stream_to_mem_rr_arb: round-robin arbiter with grant lock (req/eligible in, grant index/valid out, handshake in).
- FIFOs reuse the existing generic stream_fifo:
  - index FIFO: FALL_THROUGH=0, depth MaxOutstanding.
  - per-port response FIFOs: FALL_THROUGH=1, depth BufDepth.

Test Plan:
1. NumPorts=2, both ports valid continuously, mem ready=1, 1-cycle response → grants alternate 0,1,0,1; each port receives its own responses in order.
2. Port 0 valid, mem_req_ready_i=0 for 3 cycles, port 1 raises valid in cycle 2 → grant stays on port 0 with stable mem_req_o; port 1 is granted right after the handshake.
3. BufDepth=2, port 0 resp_ready_i=0 → after 2 handshakes, port-0 requests are blocked (req_ready_o[0]=0) while port 1 still proceeds; releasing ready drains 2 responses and unblocks.
4. MaxOutstanding=4, memory withholds responses → exactly 4 handshakes, then mem_req_valid_o=0; one response re-enables one request.
5. Response to an empty port FIFO with resp_ready_i=1 → resp_valid_o high in the same cycle as mem_resp_valid_i; credit change with a simultaneous new handshake = 0.
6. With STREAM_TO_MEM_MUX_ERR_EN: mem_resp_valid_i pulse with no outstanding → err_o=1 from the next cycle until rst_ni; no resp_valid_o. Without the macro: err_o stays 0.
